mmio_fifo_ctrl: RTL and testbench

MMIO-side controller for the AFU's 64-bit data buffer. It decodes host MMIO writes and reads, and owns the circular storage with its push/pop sequencing, occupancy counter, sticky error flags and flush. It also generates the 1-cycle-latency MMIO read response. It sits between the CCI-P Rx/Tx register stage in afu and the read-response mux, replacing direct write-enable wiring of the buffer.

---
 rtl/mmio_fifo_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mmio_fifo_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: MMIO-side controller for the AFU 64-bit data buffer.
// Decodes MMIO writes/reads into push, peek, pop, status and control actions.
// It owns the circular storage, occupancy count, sticky ovf/udf flags and flush.
// It also produces the 1-cycle MMIO read response.
// Optional feature: define MMIO_FIFO_WATERMARK_EN to add the WM register (0x0028)
// and the registered wm_hit indication (also mirrored in STATUS[20]).
module mmio_fifo_ctrl #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   input  logic [15:0] wr_addr,
   input  logic [63:0] wr_data,
   input  logic        rd_valid,
   input  logic [15:0] rd_addr,
   input  logic [8:0]  rd_tid,
   output logic        rsp_valid,
   output logic [8:0]  rsp_tid,
   output logic [63:0] rsp_data,
   output logic        rsp_hit,
   output logic        empty,
   output logic        full,
   output logic        wm_hit
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [15:0] ADDR_DATA   = 16'h0020;
   localparam logic [15:0] ADDR_POP    = 16'h0022;
   localparam logic [15:0] ADDR_STATUS = 16'h0024;
   localparam logic [15:0] ADDR_CTRL   = 16'h0026;
   localparam logic [AW:0] DEPTH_C     = (AW+1)'(DEPTH);

   // Read response handshake: there is no ready. Every rd_valid cycle produces
   // exactly one rsp_valid pulse on the following cycle, carrying the tid of
   // that read; rsp_hit says whether this block decoded the address.

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [8:0]    rsp_tid_q, rsp_tid_d;
   logic [63:0]   rsp_data_q, rsp_data_d;
   logic          rsp_hit_q, rsp_hit_d;

   logic          is_empty, is_full;
   logic          push_req, pop_req, ctrl_wr, clr, flush;
   logic          push_ok, pop_ok, push_drop, pop_udf;
   logic [63:0]   head, status;

`ifdef MMIO_FIFO_WATERMARK_EN
   localparam logic [15:0] ADDR_WM = 16'h0028;
   localparam logic [AW:0] WM_RST  = (AW+1)'(DEPTH / 2);
   logic [AW:0] wm_q, wm_d;
   logic        wm_hit_q, wm_hit_d;
`endif

   // Decode, pointer/count/flag next-state and read response next-state.
   always_comb begin
      is_empty  = (count_q == '0);
      is_full   = (count_q == DEPTH_C);
      push_req  = wr_valid && (wr_addr == ADDR_DATA);
      pop_req   = rd_valid && (rd_addr == ADDR_POP);
      ctrl_wr   = wr_valid && (wr_addr == ADDR_CTRL);
      clr       = ctrl_wr && wr_data[0];
      flush     = ctrl_wr && wr_data[1];
      // Push and pop both look at the pre-cycle occupancy.
      push_ok   = push_req && !is_full;
      push_drop = push_req && is_full;
      pop_ok    = pop_req && !is_empty;
      pop_udf   = pop_req && is_empty;
      head      = is_empty ? 64'h0 : mem_q[rd_ptr_q];

      status        = '0;
      status[AW:0]  = count_q;
      status[16]    = is_empty;
      status[17]    = is_full;
      status[18]    = ovf_q;
      status[19]    = udf_q;
`ifdef MMIO_FIFO_WATERMARK_EN
      status[20]    = wm_hit_q;
`endif

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      // Flush overrides any same-cycle pointer movement.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      // A new event beats a same-cycle clear.
      ovf_d = (ovf_q && !clr) || push_drop;
      udf_d = (udf_q && !clr) || pop_udf;

      rsp_valid_d = rd_valid;
      rsp_tid_d   = rd_tid;
      rsp_data_d  = '0;
      rsp_hit_d   = 1'b0;
      if (rd_valid) begin
         case (rd_addr)
            ADDR_DATA, ADDR_POP: begin
               rsp_hit_d  = 1'b1;
               rsp_data_d = head;
            end
            ADDR_STATUS: begin
               rsp_hit_d  = 1'b1;
               rsp_data_d = status;
            end
`ifdef MMIO_FIFO_WATERMARK_EN
            ADDR_WM: begin
               rsp_hit_d        = 1'b1;
               rsp_data_d[AW:0] = wm_q;
            end
`endif
            default: begin
               rsp_hit_d  = 1'b0;
               rsp_data_d = '0;
            end
         endcase
      end

`ifdef MMIO_FIFO_WATERMARK_EN
      wm_d = wm_q;
      if (wr_valid && (wr_addr == ADDR_WM)) wm_d = wr_data[AW:0];
      wm_hit_d = (count_q >= wm_q);
`endif
   end

   // Control state and response registers; reset has top priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         rsp_hit_q   <= 1'b0;
`ifdef MMIO_FIFO_WATERMARK_EN
         wm_q        <= WM_RST;
         wm_hit_q    <= 1'b0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_hit_q   <= rsp_hit_d;
`ifdef MMIO_FIFO_WATERMARK_EN
         wm_q        <= wm_d;
         wm_hit_q    <= wm_hit_d;
`endif
      end
   end

   // Storage write port; contents are intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tid   = rsp_tid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_hit   = rsp_hit_q;
   assign empty     = is_empty;
   assign full      = is_full;
`ifdef MMIO_FIFO_WATERMARK_EN
   assign wm_hit    = wm_hit_q;
`else
   assign wm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb_mmio_fifo_ctrl: directed bench for mmio_fifo_ctrl (DEPTH=8).
// Reads push {hit, tid, data} into exp_q; a monitor pops on each rsp_valid.
module tb_mmio_fifo_ctrl;

   localparam int W = 74;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        rd_valid = 1'b0;
   logic [15:0] rd_addr = '0;
   logic [8:0]  rd_tid = '0;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic        rsp_hit;
   logic        empty;
   logic        full;
   logic        wm_hit;

   logic [W-1:0] exp_q[$];
   int           due_q[$];
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   logic [8:0]   tid_ctr = 9'h005;

   mmio_fifo_ctrl #(.DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_tid(rd_tid),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .rsp_hit(rsp_hit), .empty(empty), .full(full), .wm_hit(wm_hit)
   );

   // clock / cycle count
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: compare every response against the head of the expected queue
   always @(negedge clk) begin
      if (rsp_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got tid=%h data=%h with no read pending", rsp_tid, rsp_data);
         end else begin
            logic [W-1:0] e;
            int d;
            e = exp_q.pop_front();
            d = due_q.pop_front();
            if ({rsp_hit, rsp_tid, rsp_data} !== e || d != cyc) begin
               bad++;
               $display("FAIL rsp: got hit=%b tid=%h data=%h cyc=%0d expected hit=%b tid=%h data=%h cyc=%0d",
                        rsp_hit, rsp_tid, rsp_data, cyc, e[73], e[72:64], e[63:0], d);
            end
         end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
         logic [W-1:0] e;
         total++;
         bad++;
         e = exp_q.pop_front();
         void'(due_q.pop_front());
         $display("FAIL rsp_missing: got no rsp_valid expected tid=%h data=%h", e[72:64], e[63:0]);
      end
   end

   // driver: one clock of stimulus, inputs released 1 time unit after the edge
   task automatic xact(input logic wv, input logic [15:0] wa, input logic [63:0] wd,
                       input logic rv, input logic [15:0] ra, input logic [8:0] tid);
      wr_valid = wv; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr = ra; rd_tid = tid;
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_valid = 1'b0;
   endtask

   task automatic expect_rsp(input logic hit, input logic [8:0] tid, input logic [63:0] data);
      exp_q.push_back({hit, tid, data});
      due_q.push_back(cyc + 1);
   endtask

   task automatic push(input logic [63:0] d);
      xact(1'b1, 16'h0020, d, 1'b0, 16'h0, 9'h0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [63:0] d);
      xact(1'b1, a, d, 1'b0, 16'h0, 9'h0);
   endtask

   task automatic rd(input logic [15:0] a, input logic hit, input logic [63:0] d);
      expect_rsp(hit, tid_ctr, d);
      xact(1'b0, 16'h0, 64'h0, 1'b1, a, tid_ctr);
      tid_ctr = tid_ctr + 9'h03b;
   endtask

   // combined write + read in the same cycle
   task automatic wr_rd(input logic [15:0] wa, input logic [63:0] wd,
                        input logic [15:0] ra, input logic hit, input logic [63:0] d);
      expect_rsp(hit, tid_ctr, d);
      xact(1'b1, wa, wd, 1'b1, ra, tid_ctr);
      tid_ctr = tid_ctr + 9'h03b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      // reset
      rst = 1'b1;
      idle(3);
      check("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      check("reset_empty", {63'h0, empty}, 64'h1);
      check("reset_full", {63'h0, full}, 64'h0);
      check("reset_wm_hit", {63'h0, wm_hit}, 64'h0);
      rst = 1'b0;

      // status after reset, tid 0x05
      rd(16'h0024, 1'b1, 64'h0001_0000);

      // basic push / peek / pop
      push(64'hA1); push(64'hA2); push(64'hA3);
      rd(16'h0020, 1'b1, 64'hA1);
      rd(16'h0024, 1'b1, 64'h0000_0003);
      rd(16'h0022, 1'b1, 64'hA1);
      rd(16'h0022, 1'b1, 64'hA2);
      rd(16'h0022, 1'b1, 64'hA3);
      rd(16'h0024, 1'b1, 64'h0001_0000);

      // overflow and pointer wrap
      for (int i = 1; i <= 9; i++) push(64'(i));
      check("full_after_fill", {63'h0, full}, 64'h1);
      check("empty_after_fill", {63'h0, empty}, 64'h0);
      rd(16'h0024, 1'b1, 64'h0006_0008);
      for (int i = 1; i <= 8; i++) rd(16'h0022, 1'b1, 64'(i));
      rd(16'h0024, 1'b1, 64'h0005_0000);
      wr(16'h0026, 64'h1);
      rd(16'h0024, 1'b1, 64'h0001_0000);

      // underflow, peek on empty, clear, clear vs new event
      rd(16'h0022, 1'b1, 64'h0);
      rd(16'h0024, 1'b1, 64'h0009_0000);
      wr(16'h0026, 64'h1);
      rd(16'h0020, 1'b1, 64'h0);
      rd(16'h0024, 1'b1, 64'h0001_0000);
      wr_rd(16'h0026, 64'h1, 16'h0022, 1'b1, 64'h0);
      rd(16'h0024, 1'b1, 64'h0009_0000);
      wr(16'h0026, 64'h1);

      // flush together with a pop
      push(64'h11); push(64'h22);
      wr_rd(16'h0026, 64'h2, 16'h0022, 1'b1, 64'h11);
      rd(16'h0024, 1'b1, 64'h0001_0000);
      push(64'h33);
      rd(16'h0022, 1'b1, 64'h33);

      // simultaneous push and pop: empty, middle, full
      wr_rd(16'h0020, 64'h44, 16'h0022, 1'b1, 64'h0);
      rd(16'h0024, 1'b1, 64'h0008_0001);
      wr(16'h0026, 64'h1);
      wr_rd(16'h0020, 64'h55, 16'h0022, 1'b1, 64'h44);
      rd(16'h0022, 1'b1, 64'h55);
      for (int i = 0; i < 8; i++) push(64'h60 + 64'(i));
      wr_rd(16'h0020, 64'h68, 16'h0022, 1'b1, 64'h60);
      rd(16'h0024, 1'b1, 64'h0004_0007);
      rd(16'h0022, 1'b1, 64'h61);
      wr(16'h0026, 64'h3);
      rd(16'h0024, 1'b1, 64'h0001_0000);

      // unmapped addresses
      rd(16'h0030, 1'b0, 64'h0);
      rd(16'h0026, 1'b0, 64'h0);

`ifdef MMIO_FIFO_WATERMARK_EN
      rd(16'h0028, 1'b1, 64'h4);
      wr(16'h0028, 64'h3);
      rd(16'h0028, 1'b1, 64'h3);
      push(64'hB1); push(64'hB2); push(64'hB3);
      check("wm_hit_same_cycle", {63'h0, wm_hit}, 64'h0);
      idle(1);
      check("wm_hit_rise", {63'h0, wm_hit}, 64'h1);
      rd(16'h0024, 1'b1, 64'h0010_0003);
      rd(16'h0022, 1'b1, 64'hB1);
      check("wm_hit_hold", {63'h0, wm_hit}, 64'h1);
      idle(1);
      check("wm_hit_fall", {63'h0, wm_hit}, 64'h0);
      wr(16'h0026, 64'h2);
`else
      wr(16'h0028, 64'h3);
      rd(16'h0028, 1'b0, 64'h0);
      check("wm_hit_tied", {63'h0, wm_hit}, 64'h0);
`endif

      // reset mid-stream: entries discarded, same-cycle read suppressed
      push(64'h77); push(64'h78);
      wr_data = '0;
      rd_valid = 1'b1; rd_addr = 16'h0024; rd_tid = 9'h1ff;
      rst = 1'b1;
      @(posedge clk); #1;
      rd_valid = 1'b0;
      check("reset_suppress_rsp", {63'h0, rsp_valid}, 64'h0);
      rst = 1'b0;
      check("reset_mid_empty", {63'h0, empty}, 64'h1);
      rd(16'h0024, 1'b1, 64'h0001_0000);

      // drain
      idle(3);
      check("exp_q_drained", 64'(exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
